// File: rtl/cpu_step_3_pkg.sv
// Shared types and constants for the piece-commit / line-clear stage.
package cpu_step_3_pkg;

   typedef enum logic [3:0] {
      IDLE,
      P_RD,
      P_WR,
      S_RD,
      S_CHK,
      SH_RD,
      SH_WR,
      CLR,
      DONE
   } state_e;

   localparam int         NUM_BLOCKS = 4;
   localparam logic [7:0] CELL_SET   = 8'd1;

endpackage

// File: rtl/cpu_step_3_row_full.sv
// Combinational full-row detect: every cell of one board row is nonzero.
module row_full #(
   parameter int MEM_WIDTH = 4,
   parameter int WIDTH     = 8
) (
   input  logic [WIDTH*MEM_WIDTH-1:0] row,
   output logic                       full
);

   always_comb begin
      full = 1'b1;
      for (int c = 0; c < MEM_WIDTH; c++) begin
         if (row[WIDTH*c +: WIDTH] == '0) full = 1'b0;
      end
   end

endmodule

// File: rtl/cpu_step_3.sv
// Piece commit into board rows, then bottom-up full-row collapse.
// Row scan/shift/clear is only built when LINE_CLEAR_EN is defined.
module cpu_step_3
   import cpu_step_3_pkg::*;
#(
   parameter int MEM_WIDTH  = 4,
   parameter int MEM_HEIGHT = 4,
   parameter int WIDTH      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [WIDTH*NUM_BLOCKS-1:0]   coord_x_in,
   input  logic [WIDTH*NUM_BLOCKS-1:0]   coord_y_in,
   output logic [WIDTH-1:0]              mem_addr,
   input  logic [WIDTH*MEM_WIDTH-1:0]    mem_rdata,
   output logic [WIDTH*MEM_WIDTH-1:0]    mem_wdata,
   output logic                          mem_we,
   output logic                          busy,
   output logic                          done,
   output logic [WIDTH-1:0]              lines_cleared,
   output logic                          game_over
);

   localparam int CW = WIDTH*NUM_BLOCKS;
   localparam logic [WIDTH-1:0] W_MW = WIDTH'(MEM_WIDTH);
   localparam logic [WIDTH-1:0] W_MH = WIDTH'(MEM_HEIGHT);

   state_e           state_q, state_d;
   logic [1:0]       k_q, k_d;
   logic [CW-1:0]    x_q, x_d, y_q, y_d;
   logic [WIDTH-1:0] lines_q, lines_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic             go_q, go_d, we_q, we_d;
   logic [WIDTH-1:0] cur_x, cur_y, nxt_x, nxt_y;

`ifdef LINE_CLEAR_EN
   logic [WIDTH-1:0] r_q, r_d, j_q, j_d;
   logic             row_is_full;

   row_full #(
      .MEM_WIDTH (MEM_WIDTH),
      .WIDTH     (WIDTH)
   ) u_row_full (
      .row  (mem_rdata),
      .full (row_is_full)
   );
`endif

   function automatic logic in_range(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
      return (x < W_MW) && (y < W_MH);
   endfunction

   assign cur_x = x_q[WIDTH*k_q +: WIDTH];
   assign cur_y = y_q[WIDTH*k_q +: WIDTH];
   assign nxt_x = x_d[WIDTH*k_d +: WIDTH];
   assign nxt_y = y_d[WIDTH*k_d +: WIDTH];

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      x_d       = x_q;
      y_d       = y_q;
      lines_d   = lines_q;
      go_d      = go_q;
      mem_wdata = '0;
`ifdef LINE_CLEAR_EN
      r_d       = r_q;
      j_d       = j_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = coord_x_in;
               y_d     = coord_y_in;
               k_d     = '0;
               lines_d = '0;
               state_d = P_RD;
            end
         end
         P_RD: state_d = P_WR;
         P_WR: begin
            mem_wdata = mem_rdata;
            for (int c = 0; c < MEM_WIDTH; c++) begin
               if (cur_x == WIDTH'(c)) begin
                  // overlap only counts when the write really lands
                  if (in_range(cur_x, cur_y) &&
                      mem_rdata[WIDTH*c +: WIDTH] != '0)
                     go_d = 1'b1;
                  mem_wdata[WIDTH*c +: WIDTH] = WIDTH'(CELL_SET);
               end
            end
            k_d = k_q + 2'd1;
            if (k_q == 2'(NUM_BLOCKS-1)) begin
`ifdef LINE_CLEAR_EN
               state_d = S_RD;
               r_d     = W_MH - 1'b1;
`else
               state_d = DONE;
`endif
            end else begin
               state_d = P_RD;
            end
         end
`ifdef LINE_CLEAR_EN
         S_RD: state_d = S_CHK;
         S_CHK: begin
            if (row_is_full) begin
               j_d     = r_q;
               // the top row has nothing above it to shift in
               state_d = (r_q == '0) ? CLR : SH_RD;
            end else if (r_q == '0) begin
               state_d = DONE;
            end else begin
               r_d     = r_q - 1'b1;
               state_d = S_RD;
            end
         end
         SH_RD: state_d = SH_WR;
         SH_WR: begin
            mem_wdata = mem_rdata;
            j_d       = j_q - 1'b1;
            state_d   = (j_q == WIDTH'(1)) ? CLR : SH_RD;
         end
         CLR: begin
            if (lines_q != '1) lines_d = lines_q + 1'b1;
            state_d = S_RD;
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // memory port is registered: decode it from the state being entered
   always_comb begin
      addr_d = '0;
      we_d   = 1'b0;
      case (state_d)
         P_RD: addr_d = nxt_y;
         P_WR: begin
            addr_d = nxt_y;
            we_d   = in_range(nxt_x, nxt_y);
         end
`ifdef LINE_CLEAR_EN
         S_RD,
         S_CHK: addr_d = r_d;
         SH_RD: addr_d = j_d - 1'b1;
         SH_WR: begin
            addr_d = j_d;
            we_d   = 1'b1;
         end
         CLR: we_d = 1'b1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         lines_q <= '0;
         go_q    <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
`ifdef LINE_CLEAR_EN
         r_q     <= '0;
         j_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         y_q     <= y_d;
         lines_q <= lines_d;
         go_q    <= go_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
`ifdef LINE_CLEAR_EN
         r_q     <= r_d;
         j_q     <= j_d;
`endif
      end
   end

   assign mem_addr      = addr_q;
   assign mem_we        = we_q;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign lines_cleared = lines_q;
   assign game_over     = go_q;

endmodule
